pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32 integer core. It watches the ID and EXE stages and drives per-stage hold and bubble-insert controls for `pc_reg`, `if_id`, `id_exe`, `exe_mem` and `mem_wb`. It resolves three conditions:
- load-use hazards;
- multi-cycle EXE operations;
- taken branch/jump redirects, including discarding the extra in-flight fetch caused by the registered ROM read.

A saturating stall-cycle counter and a multi-cycle timeout flag support debug.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, instruction address width.
- `RADDR_WIDTH`, 5, register index width.
- `FLUSH_CYCLES`, 1, extra wrong-path fetch cycles discarded after a redirect (1..3).
- `MC_TIMEOUT`, 64, MC_WAIT cycles before `mc_timeout_o` is raised.
- `CNT_WIDTH`, 16, stall counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `id_reg1_re_i`, `id_reg2_re_i`  in  1 each  ID source read enables.
- `id_reg1_raddr_i`, `id_reg2_raddr_i`  in  `RADDR_WIDTH` each  ID source indices.
- `ex_reg_we_i`  in  1  EXE instruction writes rd.
- `ex_reg_waddr_i`  in  `RADDR_WIDTH`  EXE rd index.
- `ex_is_load_i`  in  1  EXE instruction is a load.
- `ex_mc_req_i`  in  1  EXE instruction uses the multi-cycle unit; held while it sits in EXE.
- `ex_mc_done_i`  in  1  multi-cycle result valid this cycle.
- `ex_jump_i`  in  1  taken branch/jump resolved in EXE.
- `ex_jump_addr_i`  in  `ADDR_WIDTH`  redirect target.
- `stall_o`  out  5  hold enables: bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb.
- `flush_o`  out  5  bubble-insert enables, same bit order (a bubble has we=0 and inst=NOP).
- `pc_redirect_o`  out  1  `pc_reg` loads `pc_redirect_addr_o` at the next edge.
- `pc_redirect_addr_o`  out  `ADDR_WIDTH`  redirect target.
- `state_o`  out  2  FSM state: RUN=0, MC_WAIT=1, FLUSH=2.
- `mc_timeout_o`  out  1  sticky error flag.
- `stall_cnt_o`  out  `CNT_WIDTH`  count of cycles with `stall_o[0]`=1; saturating.

## Operation
- **Stage control priority.** For each stage: `flush_o` bit beats `stall_o` bit, which beats a normal load. `pc_redirect_o` beats `stall_o[0]`.
- **Hazard detect.** `lu` = `ex_is_load_i` & `ex_reg_we_i` & (`ex_reg_waddr_i`≠0) & ((`id_reg1_re_i` & `id_reg1_raddr_i`==`ex_reg_waddr_i`) | (`id_reg2_re_i` & `id_reg2_raddr_i`==`ex_reg_waddr_i`)).
- **FSM.** Registered state; Mealy outputs.
- **RUN, priority order:**
  1. `ex_jump_i`: `pc_redirect_o`=1, `flush_o`[2:1]=11. Go to FLUSH with `fcnt`=`FLUSH_CYCLES`.
  2. `ex_mc_req_i` & !`ex_mc_done_i`: `stall_o`[2:0]=111, `flush_o`[3]=1. Go to MC_WAIT with `tcnt`=1.
  3. `lu`: `stall_o`[1:0]=11, `flush_o`[2]=1. Stay in RUN.
  4. Otherwise: all outputs 0.
- **MC_WAIT:**
  - If !`ex_mc_done_i`: `stall_o`[2:0]=111, `flush_o`[3]=1, `tcnt`++ (saturating). Set `mc_timeout_o` when `tcnt`==`MC_TIMEOUT`. Keep waiting.
  - If `ex_mc_done_i`: all outputs 0, EXE result enters `exe_mem`. Go to RUN.
  - `ex_jump_i` and `lu` are ignored in MC_WAIT.
- **FLUSH:**
  - `flush_o`[1]=1 (discard the wrong-path ROM word). `lu` and `ex_jump_i` are ignored, since EXE/ID hold bubbles.
  - `fcnt`-- each cycle; go to RUN in the cycle `fcnt`==1.
- **Outputs not listed** for a case are 0. `stall_o`[4:3] are 0 in every state (MEM/WB never hold).
- **`pc_redirect_addr_o`** = `ex_jump_addr_i` when `pc_redirect_o`=1, else 0.
- **`stall_cnt_o`** increments each cycle `stall_o[0]`=1 and holds at all-ones.
- **`mc_timeout_o`** clears only on reset.

## Timing
- **Reset.** Asserting `rst_i` forces state=RUN, `fcnt`=`tcnt`=0, `stall_cnt_o`=0, `mc_timeout_o`=0 immediately. All combinational outputs are 0 while reset is asserted. This applies mid-MC_WAIT and mid-FLUSH; no redirect survives reset.
- **Control latency.** All control outputs are valid in the same cycle as the causing inputs and act at the next rising edge.
- **Load-use.** Costs exactly 1 bubble. Next cycle the load is in MEM and `lu` is 0.
- **Multi-cycle.** A multi-cycle op with done arriving N cycles after entering EXE costs N stall cycles. Done in the first EXE cycle costs 0.
- **Redirect.** Costs 2 + `FLUSH_CYCLES` bubbles. The target instruction reaches ID at cycle 2 + `FLUSH_CYCLES` after the jump cycle.
- **Simultaneous events.** `ex_jump_i` together with `ex_mc_req_i` in RUN: jump wins and the request is dropped (the requester must not jump). `ex_mc_done_i` without a request in RUN is ignored.

## Test plan
- **Load-use.** `lw x5` in EXE, `add x6,x5,x1` in ID -> one cycle with `stall_o`=00011, `flush_o`=00100; next cycle outputs 0, `stall_cnt_o`=1.
- **Multi-cycle.** `ex_mc_req_i`=1, done asserted 4 cycles later -> `state_o`=1 for 4 cycles with `stall_o`=00111, `flush_o`=01000; done cycle outputs 0, `state_o` returns to 0, `stall_cnt_o`=4.
- **Redirect.** `ex_jump_i`=1, addr 0x0000_0040, `FLUSH_CYCLES`=1 -> `pc_redirect_o`=1 with addr 0x40 and `flush_o`=00110; next cycle `state_o`=2 with `flush_o`=00010; then RUN.
- **Timeout.** `MC_TIMEOUT`=8, request held 10 cycles with no done -> `mc_timeout_o` rises on cycle 8 and stays 1 after done and return to RUN.
- **Reset mid-operation.** `rst_i` pulsed mid-MC_WAIT and mid-FLUSH -> all outputs 0 asynchronously, `state_o`=0, counters 0. A `lu` condition in the first post-reset cycle is handled normally.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: load-use bubbles,
// multi-cycle EXE stalls and branch/jump redirect flushes, with debug counters.
module pipe_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int RADDR_WIDTH  = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_reg1_re_i,
  input  logic                   id_reg2_re_i,
  input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
  input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
  input  logic                   ex_reg_we_i,
  input  logic [RADDR_WIDTH-1:0] ex_reg_waddr_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_mc_req_i,
  input  logic                   ex_mc_done_i,
  input  logic                   ex_jump_i,
  input  logic [ADDR_WIDTH-1:0]  ex_jump_addr_i,
  output logic [4:0]             stall_o,
  output logic [4:0]             flush_o,
  output logic                   pc_redirect_o,
  output logic [ADDR_WIDTH-1:0]  pc_redirect_addr_o,
  output logic [1:0]             state_o,
  output logic                   mc_timeout_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  // state   | meaning
  // RUN     | normal issue; hazards and redirects resolved here
  // MC_WAIT | multi-cycle EXE op outstanding, front end held
  // FLUSH   | discarding wrong-path ROM words after a redirect
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1, FLUSH = 2'd2} state_e;

  localparam int TW = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_MAX  = TW'(MC_TIMEOUT);
  localparam logic [1:0]    FCNT_INIT = 2'(FLUSH_CYCLES);

  state_e               state_q, state_d;
  logic [1:0]           fcnt_q, fcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 lu;

  assign lu = ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != '0) &
              ((id_reg1_re_i & (id_reg1_raddr_i == ex_reg_waddr_i)) |
               (id_reg2_re_i & (id_reg2_raddr_i == ex_reg_waddr_i)));

  always_comb begin
    state_d            = state_q;
    fcnt_d             = fcnt_q;
    tcnt_d             = tcnt_q;
    stall_o            = '0;
    flush_o            = '0;
    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = '0;
    // Reset gates the Mealy outputs so no redirect or hold escapes while held.
    if (!rst_i) begin
      unique case (state_q)
        RUN: begin
          if (ex_jump_i) begin
            pc_redirect_o      = 1'b1;
            pc_redirect_addr_o = ex_jump_addr_i;
            flush_o            = 5'b00110;
            fcnt_d             = FCNT_INIT;
            state_d            = FLUSH;
          end else if (ex_mc_req_i && !ex_mc_done_i) begin
            stall_o = 5'b00111;
            flush_o = 5'b01000;
            tcnt_d  = TW'(1);
            state_d = MC_WAIT;
          end else if (lu) begin
            stall_o = 5'b00011;
            flush_o = 5'b00100;
          end
        end
        MC_WAIT: begin
          if (ex_mc_done_i) begin
            tcnt_d  = '0;
            state_d = RUN;
          end else begin
            stall_o = 5'b00111;
            flush_o = 5'b01000;
            if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + TW'(1);
          end
        end
        FLUSH: begin
          flush_o = 5'b00010;
          fcnt_d  = fcnt_q - 2'd1;
          if (fcnt_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    timeout_d   = timeout_q | (stall_o[2] & (tcnt_d == TCNT_MAX));
    stall_cnt_d = stall_cnt_q;
    if (stall_o[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o      = state_q;
  assign mc_timeout_o = timeout_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// each cycle checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int FC = 2;
  localparam int TO = 8;
  localparam int CW = 6;

  typedef struct {
    logic          rst;
    logic          r1re, r2re;
    logic [RW-1:0] r1a, r2a;
    logic          we;
    logic [RW-1:0] wa;
    logic          ld, req, done, jump;
    logic [AW-1:0] ja;
  } vec_t;

  typedef struct {
    logic [4:0]    stall, flush;
    logic          redir;
    logic [AW-1:0] raddr;
    logic [1:0]    state;
    logic          to;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r1re = 0, r2re = 0, we = 0, ld = 0, req = 0, done = 0, jump = 0;
  logic [RW-1:0] r1a = '0, r2a = '0, wa = '0;
  logic [AW-1:0] ja = '0;
  logic [4:0] stall_o, flush_o;
  logic redir_o;
  logic [AW-1:0] raddr_o;
  logic [1:0] state_o;
  logic to_o;
  logic [CW-1:0] cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_WIDTH(AW), .RADDR_WIDTH(RW), .FLUSH_CYCLES(FC),
              .MC_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_reg1_re_i(r1re), .id_reg2_re_i(r2re),
    .id_reg1_raddr_i(r1a), .id_reg2_raddr_i(r2a),
    .ex_reg_we_i(we), .ex_reg_waddr_i(wa), .ex_is_load_i(ld),
    .ex_mc_req_i(req), .ex_mc_done_i(done),
    .ex_jump_i(jump), .ex_jump_addr_i(ja),
    .stall_o(stall_o), .flush_o(flush_o),
    .pc_redirect_o(redir_o), .pc_redirect_addr_o(raddr_o),
    .state_o(state_o), .mc_timeout_o(to_o), .stall_cnt_o(cnt_o)
  );

  // Reference model: what the pipeline is doing, in plain counts.
  int m_mode       = 0;   // 0 running, 1 waiting on multi-cycle, 2 discarding fetches
  int m_flush_left = 0;
  int m_mc_stalls  = 0;
  bit m_timeout    = 0;
  int m_stalls     = 0;
  exp_t expq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_step(input vec_t v, output exp_t e);
    bit hazard;
    e = '{stall: 5'b0, flush: 5'b0, redir: 1'b0, raddr: '0, state: 2'(m_mode),
          to: m_timeout, cnt: CW'(m_stalls)};
    if (v.rst) begin
      m_mode = 0; m_flush_left = 0; m_mc_stalls = 0; m_timeout = 0; m_stalls = 0;
      e = '{stall: 5'b0, flush: 5'b0, redir: 1'b0, raddr: '0, state: 2'd0,
            to: 1'b0, cnt: '0};
      return;
    end
    hazard = v.ld && v.we && v.wa != 0 &&
             ((v.r1re && v.r1a == v.wa) || (v.r2re && v.r2a == v.wa));
    case (m_mode)
      0: begin
        if (v.jump) begin
          e.redir = 1; e.raddr = v.ja; e.flush = 5'b00110;
          m_mode = 2; m_flush_left = FC;
        end else if (v.req && !v.done) begin
          e.stall = 5'b00111; e.flush = 5'b01000;
          m_mode = 1; m_mc_stalls = 1;
          if (m_mc_stalls >= TO) m_timeout = 1;
        end else if (hazard) begin
          e.stall = 5'b00011; e.flush = 5'b00100;
        end
      end
      1: begin
        if (v.done) m_mode = 0;
        else begin
          e.stall = 5'b00111; e.flush = 5'b01000;
          m_mc_stalls++;
          if (m_mc_stalls >= TO) m_timeout = 1;
        end
      end
      default: begin
        e.flush = 5'b00010;
        m_flush_left--;
        if (m_flush_left == 0) m_mode = 0;
      end
    endcase
    if (e.stall[0]) m_stalls = (m_stalls + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_stalls + 1;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; r1re = v.r1re; r2re = v.r2re; r1a = v.r1a; r2a = v.r2a;
    we = v.we; wa = v.wa; ld = v.ld; req = v.req; done = v.done;
    jump = v.jump; ja = v.ja;
    model_step(v, e);
    expq.push_back(e);
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{rst: 0, r1re: 0, r2re: 0, r1a: '0, r2a: '0, we: 0, wa: '0,
          ld: 0, req: 0, done: 0, jump: 0, ja: '0};
    return v;
  endfunction

  function automatic vec_t lu_vec();
    vec_t v;
    v = nop();
    v.ld = 1; v.we = 1; v.wa = 5'd5; v.r2re = 1; v.r2a = 5'd5;
    v.r1re = 1; v.r1a = 5'd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got 0x%0h expected 0x%0h", name, vectors, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      chk("stall_o", 32'(stall_o), 32'(e.stall));
      chk("flush_o", 32'(flush_o), 32'(e.flush));
      chk("pc_redirect_o", 32'(redir_o), 32'(e.redir));
      chk("pc_redirect_addr_o", raddr_o, e.raddr);
      chk("state_o", 32'(state_o), 32'(e.state));
      chk("mc_timeout_o", 32'(to_o), 32'(e.to));
      chk("stall_cnt_o", 32'(cnt_o), 32'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    v = nop(); v.rst = 1;
    apply(v); apply(v);
    // load-use: one bubble, then clear
    apply(lu_vec());
    apply(nop());
    // load with rd = x0 never hazards; no read-enable never hazards
    v = lu_vec(); v.wa = 0; v.r2a = 0; apply(v);
    v = lu_vec(); v.r2re = 0; apply(v);
    // multi-cycle, done four cycles after entry
    v = nop(); v.req = 1;
    for (int i = 0; i < 4; i++) apply(v);
    v.done = 1; apply(v);
    // done in first EXE cycle costs nothing
    apply(v);
    apply(nop());
    // redirect
    v = nop(); v.jump = 1; v.ja = 32'h0000_0040; apply(v);
    v = lu_vec(); v.jump = 1; apply(v); apply(v);
    apply(nop());
    // jump beats a simultaneous request
    v = nop(); v.jump = 1; v.req = 1; v.ja = 32'h1234_5678; apply(v);
    for (int i = 0; i < FC; i++) apply(nop());
    // timeout: request held 10 cycles, then done
    v = nop(); v.req = 1;
    for (int i = 0; i < 10; i++) apply(v);
    v.done = 1; apply(v);
    apply(nop());
    // reset mid-MC_WAIT, then load-use right after
    v = nop(); v.req = 1;
    for (int i = 0; i < 3; i++) apply(v);
    v.rst = 1; apply(v);
    apply(lu_vec());
    apply(nop());
    // reset mid-FLUSH with a jump still asserted
    v = nop(); v.jump = 1; v.ja = 32'hdead_beef; apply(v);
    v.rst = 1; apply(v);
    apply(lu_vec());
    apply(nop());
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      v = nop();
      v.rst  = ($urandom_range(0, 199) == 0);
      v.r1re = 1'($urandom_range(0, 1));
      v.r2re = 1'($urandom_range(0, 1));
      v.r1a  = RW'($urandom_range(0, 3));
      v.r2a  = RW'($urandom_range(0, 3));
      v.wa   = RW'($urandom_range(0, 3));
      v.we   = 1'($urandom_range(0, 3) != 0);
      v.ld   = 1'($urandom_range(0, 1));
      v.ja   = $urandom;
      v.jump = ($urandom_range(0, 9) == 0);
      if (m_mode == 1) begin
        v.req  = 1;
        v.done = ($urandom_range(0, 5) == 0);
      end else begin
        v.req  = ($urandom_range(0, 5) == 0);
        v.done = v.req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      end
      apply(v);
    end
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
